// File: rtl/sccb_arb_pkg.sv
// Shared types and constants for the SCCB request arbiter.
package sccb_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } arb_state_t;

  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

  // Adds two 32-bit values, clamping at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/sccb_rr_pick.sv
// Two-way round-robin picker: when both ports request, the one not served last wins.
module sccb_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_idx
);

  // Pure combinational choice of the next port to serve.
  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/sccb_req_arbiter.sv
// Shares one iic_control master between the boot loader (port 0) and the
// runtime register port (port 1); retries NACKs and guards against a hung bus.
module sccb_req_arbiter
  import sccb_arb_pkg::*;
#(
  parameter logic [7:0]  DEVICE_ID     = 8'h78,
  parameter logic        ADDR_MODE     = 1'b1,
  parameter int unsigned MAX_RETRY     = 3,
  parameter logic [15:0] RETRY_GAP_CYC = 16'd500,
  parameter logic [31:0] TIMEOUT_CYC   = 32'd2_000_000
) (
  input  logic        i_sysclk,
  input  logic        i_sysrst,
  input  logic        r0_req,
  input  logic        r0_rd,
  input  logic [15:0] r0_addr,
  input  logic [7:0]  r0_wdata,
  input  logic [31:0] r0_dly,
  output logic        r0_done,
  output logic        r0_err,
  output logic [7:0]  r0_rdata,
  input  logic        r1_req,
  input  logic        r1_rd,
  input  logic [15:0] r1_addr,
  input  logic [7:0]  r1_wdata,
  input  logic [31:0] r1_dly,
  output logic        r1_done,
  output logic        r1_err,
  output logic [7:0]  r1_rdata,
  output logic        bus_fault,
  output logic        wrreg_req,
  output logic        rdreg_req,
  output logic [15:0] addr,
  output logic [7:0]  wr_data,
  output logic [31:0] dly_cnt_max,
  output logic [7:0]  device_id,
  output logic        addr_mode,
  input  logic [7:0]  rd_data,
  input  logic        rw_done,
  input  logic        ack
);

  localparam logic [2:0] MAX_RETRY_C = 3'(MAX_RETRY);

  arb_state_t  state, state_next;
  logic        last_served;
  logic        gnt_idx;
  logic        lat_rd;
  logic [15:0] lat_addr;
  logic [7:0]  lat_wdata;
  logic [31:0] lat_dly;
  logic [2:0]  retry_cnt;
  logic [15:0] gap_cnt;
  logic [31:0] tmo_cnt;
  logic [31:0] tmo_limit;
  logic        res_err;
  logic [7:0]  res_rdata;
  logic        pick_valid;
  logic        pick_idx;
  logic        grant_take;
  logic        done_busy;
  logic        tmo_hit;
  logic        gap_end;
  logic        xfer_active;

  sccb_rr_pick u_pick (
    .req         ({r1_req, r0_req}),
    .last        (last_served),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  assign device_id   = DEVICE_ID;
  assign addr_mode   = ADDR_MODE;

  // A requester still sees its done pulse this cycle, so its req is not yet meaningful.
  assign done_busy   = r0_done | r1_done;
  assign tmo_limit   = sat_add32(TIMEOUT_CYC, lat_dly);
  assign tmo_hit     = (tmo_cnt == tmo_limit);
  assign gap_end     = (({1'b0, gap_cnt} + 17'd1) >= {1'b0, RETRY_GAP_CYC});
  assign xfer_active = (state == ISSUE) || (state == WAIT);
  assign addr        = xfer_active ? lat_addr  : 16'd0;
  assign wr_data     = xfer_active ? lat_wdata : 8'd0;
  assign dly_cnt_max = xfer_active ? lat_dly   : 32'd0;

  // State register.
  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state decode and the one-cycle request strobes to iic_control.
  always_comb begin
    state_next = state;
    grant_take = 1'b0;
    wrreg_req  = 1'b0;
    rdreg_req  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid && !done_busy) begin
          grant_take = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        rdreg_req  = (lat_rd == OP_RD);
        wrreg_req  = (lat_rd == OP_WR);
        state_next = WAIT;
      end
      WAIT: begin
        if (rw_done) begin
          if (!ack)                         state_next = DONE;
          else if (retry_cnt < MAX_RETRY_C) state_next = GAP;
          else                              state_next = DONE;
        end else if (tmo_hit) begin
          state_next = DONE;
        end
      end
      GAP: begin
        if (gap_end) state_next = ISSUE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the granted port's transfer fields so later req changes cannot disturb it.
  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      gnt_idx   <= 1'b0;
      lat_rd    <= OP_WR;
      lat_addr  <= 16'd0;
      lat_wdata <= 8'd0;
      lat_dly   <= 32'd0;
    end else if (grant_take) begin
      gnt_idx   <= pick_idx;
      lat_rd    <= pick_idx ? r1_rd    : r0_rd;
      lat_addr  <= pick_idx ? r1_addr  : r0_addr;
      lat_wdata <= pick_idx ? r1_wdata : r0_wdata;
      lat_dly   <= pick_idx ? r1_dly   : r0_dly;
    end
  end

  // Retry, gap and timeout counters; the timeout counter saturates rather than wraps.
  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      retry_cnt <= 3'd0;
      gap_cnt   <= 16'd0;
      tmo_cnt   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_take) retry_cnt <= 3'd0;
        end
        ISSUE: tmo_cnt <= 32'd0;
        WAIT: begin
          if (tmo_cnt != 32'hFFFF_FFFF) tmo_cnt <= tmo_cnt + 32'd1;
          if (rw_done && ack && (retry_cnt < MAX_RETRY_C)) begin
            retry_cnt <= retry_cnt + 3'd1;
            gap_cnt   <= 16'd0;
          end
        end
        GAP: gap_cnt <= gap_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  // Transfer outcome, sticky bus fault and round-robin history.
  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      res_err     <= 1'b0;
      res_rdata   <= 8'd0;
      bus_fault   <= 1'b0;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (grant_take) begin
            res_err   <= 1'b0;
            res_rdata <= 8'd0;
          end
        end
        WAIT: begin
          if (rw_done) begin
            if (!ack) begin
              res_err   <= 1'b0;
              res_rdata <= rd_data;
            end else if (retry_cnt >= MAX_RETRY_C) begin
              res_err <= 1'b1;
            end
          end else if (tmo_hit) begin
            res_err   <= 1'b1;
            bus_fault <= 1'b1;
          end
        end
        DONE: last_served <= gnt_idx;
        default: ;
      endcase
    end
  end

  // Per-port completion pulse, error flag and read data, registered out of DONE.
  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      r0_done  <= 1'b0;
      r0_err   <= 1'b0;
      r0_rdata <= 8'd0;
      r1_done  <= 1'b0;
      r1_err   <= 1'b0;
      r1_rdata <= 8'd0;
    end else begin
      r0_done <= (state == DONE) && !gnt_idx;
      r0_err  <= (state == DONE) && !gnt_idx && res_err;
      r1_done <= (state == DONE) && gnt_idx;
      r1_err  <= (state == DONE) && gnt_idx && res_err;
      if ((state == DONE) && !gnt_idx) r0_rdata <= res_rdata;
      if ((state == DONE) && gnt_idx)  r1_rdata <= res_rdata;
    end
  end

endmodule

// File: tb/tb_sccb_req_arbiter.sv
// Directed bench for sccb_req_arbiter with a hand-driven iic_control responder.
module tb_sccb_req_arbiter;

  logic        i_sysclk = 1'b0;
  logic        i_sysrst;
  logic        r0_req, r0_rd, r1_req, r1_rd;
  logic [15:0] r0_addr, r1_addr;
  logic [7:0]  r0_wdata, r1_wdata;
  logic [31:0] r0_dly, r1_dly;
  logic        r0_done, r0_err, r1_done, r1_err;
  logic [7:0]  r0_rdata, r1_rdata;
  logic        bus_fault, wrreg_req, rdreg_req;
  logic [15:0] addr;
  logic [7:0]  wr_data;
  logic [31:0] dly_cnt_max;
  logic [7:0]  device_id;
  logic        addr_mode;
  logic [7:0]  rd_data;
  logic        rw_done, ack;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int d0 = 0;
  int d1 = 0;

  sccb_req_arbiter #(
    .TIMEOUT_CYC (32'd1000)
  ) dut (
    .i_sysclk    (i_sysclk),
    .i_sysrst    (i_sysrst),
    .r0_req      (r0_req),
    .r0_rd       (r0_rd),
    .r0_addr     (r0_addr),
    .r0_wdata    (r0_wdata),
    .r0_dly      (r0_dly),
    .r0_done     (r0_done),
    .r0_err      (r0_err),
    .r0_rdata    (r0_rdata),
    .r1_req      (r1_req),
    .r1_rd       (r1_rd),
    .r1_addr     (r1_addr),
    .r1_wdata    (r1_wdata),
    .r1_dly      (r1_dly),
    .r1_done     (r1_done),
    .r1_err      (r1_err),
    .r1_rdata    (r1_rdata),
    .bus_fault   (bus_fault),
    .wrreg_req   (wrreg_req),
    .rdreg_req   (rdreg_req),
    .addr        (addr),
    .wr_data     (wr_data),
    .dly_cnt_max (dly_cnt_max),
    .device_id   (device_id),
    .addr_mode   (addr_mode),
    .rd_data     (rd_data),
    .rw_done     (rw_done),
    .ack         (ack)
  );

  // Free-running clock.
  always #5 i_sysclk = ~i_sysclk;

  // Cycle stamp and running count of done pulses per port.
  always @(posedge i_sysclk) begin
    cyc <= cyc + 1;
    if (r0_done) d0 <= d0 + 1;
    if (r1_done) d1 <= d1 + 1;
  end

  // Hard stop in case something goes badly wrong.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge i_sysclk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int port, input logic rd, input logic [15:0] a,
                               input logic [7:0] wd, input logic [31:0] dly);
    if (port == 0) begin
      r0_rd = rd; r0_addr = a; r0_wdata = wd; r0_dly = dly; r0_req = 1'b1;
    end else begin
      r1_rd = rd; r1_addr = a; r1_wdata = wd; r1_dly = dly; r1_req = 1'b1;
    end
  endtask

  task automatic dropReq(input int port);
    if (port == 0) r0_req = 1'b0;
    else           r1_req = 1'b0;
  endtask

  task automatic respond(input logic nack, input logic [7:0] data);
    rw_done = 1'b1; ack = nack; rd_data = data;
    tick();
    rw_done = 1'b0; ack = 1'b0; rd_data = 8'd0;
  endtask

  task automatic waitIssue(output int stamp);
    bit found = 1'b0;
    stamp = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      if (wrreg_req || rdreg_req) begin
        found = 1'b1;
        stamp = cyc;
      end
    end
    if (!found) checkOutput("issue_seen", 32'd0, 32'd1);
  endtask

  task automatic runXfer(input int port, input logic [15:0] expAddr, input logic expRd,
                         input int nacks, input logic [7:0] data, input logic expErr,
                         input string tag);
    int attempts;
    int stamp;
    int prevStamp;
    attempts  = (nacks > 3) ? 4 : nacks + 1;
    prevStamp = 0;
    for (int i = 0; i < attempts; i++) begin
      waitIssue(stamp);
      checkOutput({tag, "_addr"}, 32'(addr), 32'(expAddr));
      checkOutput({tag, "_op"}, 32'({rdreg_req, wrreg_req}), expRd ? 32'd2 : 32'd1);
      if (i > 0) checkOutput({tag, "_spacing"}, 32'(stamp - prevStamp), 32'd504);
      prevStamp = stamp;
      repeat (3) tick();
      respond(i < nacks, data);
    end
    tick();
    if (port == 0) begin
      checkOutput({tag, "_done"}, 32'({r1_done, r0_done}), 32'd1);
      checkOutput({tag, "_err"}, 32'(r0_err), 32'(expErr));
      if (expRd) checkOutput({tag, "_rdata"}, 32'(r0_rdata), 32'(data));
    end else begin
      checkOutput({tag, "_done"}, 32'({r1_done, r0_done}), 32'd2);
      checkOutput({tag, "_err"}, 32'(r1_err), 32'(expErr));
      if (expRd) checkOutput({tag, "_rdata"}, 32'(r1_rdata), 32'(data));
    end
    dropReq(port);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"},
                32'({r0_done, r1_done, r0_err, r1_err, bus_fault, wrreg_req, rdreg_req,
                     r0_rdata, r1_rdata}), 32'd0);
    checkOutput({tag, "_bus"}, 32'({addr, wr_data}), 32'd0);
    checkOutput({tag, "_dly"}, dly_cnt_max, 32'd0);
  endtask

  initial begin
    int stamp;
    int start;
    int d0s;
    int d1s;

    i_sysrst = 1'b1;
    r0_req = 1'b0; r0_rd = 1'b0; r0_addr = 16'd0; r0_wdata = 8'd0; r0_dly = 32'd0;
    r1_req = 1'b0; r1_rd = 1'b0; r1_addr = 16'd0; r1_wdata = 8'd0; r1_dly = 32'd0;
    rw_done = 1'b0; ack = 1'b0; rd_data = 8'd0;
    repeat (3) tick();
    checkAllZero("reset");
    checkOutput("device_id", 32'(device_id), 32'h78);
    checkOutput("addr_mode", 32'(addr_mode), 32'd1);
    i_sysrst = 1'b0;
    tick();

    $display("[TB] single write");
    d0s   = d0;
    start = cyc;
    applyStimulus(0, 1'b0, 16'h3008, 8'h82, 32'h40000);
    waitIssue(stamp);
    checkOutput("wr_latency", 32'(stamp - start), 32'd1);
    checkOutput("wr_pulse", 32'({rdreg_req, wrreg_req}), 32'd1);
    checkOutput("wr_addr", 32'(addr), 32'h3008);
    checkOutput("wr_data", 32'(wr_data), 32'h82);
    checkOutput("wr_dly", dly_cnt_max, 32'h40000);
    tick();
    checkOutput("wr_pulse_len", 32'({rdreg_req, wrreg_req}), 32'd0);
    checkOutput("wr_dly_wait", dly_cnt_max, 32'h40000);
    tick();
    tick();
    respond(1'b0, 8'h00);
    tick();
    checkOutput("wr_done", 32'({r1_done, r0_done}), 32'd1);
    checkOutput("wr_err", 32'(r0_err), 32'd0);
    dropReq(0);
    repeat (4) tick();
    checkOutput("wr_done_once", 32'(d0 - d0s), 32'd1);
    checkOutput("wr_dly_idle", dly_cnt_max, 32'd0);

    $display("[TB] nack retry then ack");
    applyStimulus(0, 1'b0, 16'h3100, 8'h11, 32'd0);
    runXfer(0, 16'h3100, 1'b0, 2, 8'h00, 1'b0, "nack2");
    repeat (3) tick();

    $display("[TB] nack exhausts retries");
    applyStimulus(0, 1'b0, 16'h3101, 8'h22, 32'd0);
    runXfer(0, 16'h3101, 1'b0, 4, 8'h00, 1'b1, "nack4");
    repeat (3) tick();

    $display("[TB] timeout");
    checkOutput("fault_before", 32'(bus_fault), 32'd0);
    applyStimulus(0, 1'b0, 16'h3102, 8'h33, 32'd0);
    waitIssue(stamp);
    repeat (1002) tick();
    checkOutput("tmo_not_yet", 32'(r0_done), 32'd0);
    checkOutput("tmo_fault_set", 32'(bus_fault), 32'd1);
    tick();
    checkOutput("tmo_done", 32'(r0_done), 32'd1);
    checkOutput("tmo_err", 32'(r0_err), 32'd1);
    dropReq(0);
    repeat (3) tick();

    $display("[TB] read on port 1");
    applyStimulus(1, 1'b1, 16'h300A, 8'h00, 32'h10);
    runXfer(1, 16'h300A, 1'b1, 0, 8'h56, 1'b0, "rd");
    checkOutput("fault_sticky", 32'(bus_fault), 32'd1);
    repeat (3) tick();
    d0s = d0;
    d1s = d1;
    rw_done = 1'b1; ack = 1'b0; rd_data = 8'hAA;
    tick();
    rw_done = 1'b0; rd_data = 8'h00;
    repeat (5) tick();
    checkOutput("stray_no_done", 32'((d0 - d0s) + (d1 - d1s)), 32'd0);
    checkOutput("rdata_held", 32'(r1_rdata), 32'h56);
    applyStimulus(0, 1'b0, 16'h3103, 8'h44, 32'd0);
    runXfer(0, 16'h3103, 1'b0, 0, 8'h00, 1'b0, "other");
    checkOutput("rdata_held2", 32'(r1_rdata), 32'h56);
    repeat (3) tick();

    $display("[TB] reset mid-wait");
    applyStimulus(0, 1'b0, 16'h3104, 8'h55, 32'h5);
    waitIssue(stamp);
    tick();
    tick();
    i_sysrst = 1'b1;
    #1;
    checkAllZero("midrst");
    tick();
    dropReq(0);
    repeat (2) tick();
    i_sysrst = 1'b0;
    d0s = d0;
    d1s = d1;
    repeat (20) tick();
    checkOutput("midrst_no_done", 32'((d0 - d0s) + (d1 - d1s)), 32'd0);

    $display("[TB] contention after reset");
    start = cyc;
    applyStimulus(0, 1'b0, 16'h1000, 8'h01, 32'd0);
    applyStimulus(1, 1'b0, 16'h2000, 8'h02, 32'd0);
    for (int k = 0; k < 4; k++) begin
      waitIssue(stamp);
      if (k == 0) checkOutput("cont_latency", 32'(stamp - start), 32'd1);
      checkOutput("cont_addr", 32'(addr), (k % 2 == 0) ? 32'h1000 : 32'h2000);
      repeat (3) tick();
      respond(1'b0, 8'h00);
      tick();
      checkOutput("cont_done", 32'({r1_done, r0_done}), (k % 2 == 0) ? 32'd1 : 32'd2);
    end
    dropReq(0);
    dropReq(1);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sccb_req_arbiter.md
Name: sccb_req_arbiter

Overview:
- Shares the single iic_control master between two requesters:
  - port 0: the boot-time register loader;
  - port 1: runtime register access, e.g. exposure/gain tuning or a debug bridge.
- Runs one transaction at a time, round-robin between the ports.
- Retries NACKed transfers, guards against a hung bus with a timeout, and returns read data and status per requester.
- Sits between the camera configuration logic and iic_control inside the camera top.

Parameters:
- DEVICE_ID, 8'h78: SCCB slave address driven to iic_control.
- ADDR_MODE, 1'b1: 1 = 16-bit register address, 0 = 8-bit.
- MAX_RETRY, 3: extra attempts after a NACK, range 0..7.
- RETRY_GAP_CYC, 16'd500: idle cycles between a NACK and the re-issue.
- TIMEOUT_CYC, 32'd2_000_000: cycles allowed in WAIT, on top of the latched delay.

Ports:
- i_sysclk  in  1  system clock
- i_sysrst  in  1  reset, asynchronous, active-high
- r0_req, r1_req  in  1  level request; held with its fields stable until the matching done
- r0_rd, r1_rd  in  1  1 = read, 0 = write
- r0_addr, r1_addr  in  16  register address
- r0_wdata, r1_wdata  in  8  write data
- r0_dly, r1_dly  in  32  post-transfer delay forwarded as dly_cnt_max
- r0_done, r1_done  out  1  one-cycle completion pulse
- r0_err, r1_err  out  1  valid with done; 1 = NACK after all retries, or timeout
- r0_rdata, r1_rdata  out  8  read result; valid with done, held until the next grant to that port
- bus_fault  out  1  sticky; set by any timeout
- wrreg_req, rdreg_req  out  1  one-cycle request pulses to iic_control
- addr  out  16  to iic_control
- wr_data  out  8  to iic_control
- dly_cnt_max  out  32  to iic_control
- device_id  out  8  constant DEVICE_ID
- addr_mode  out  1  constant ADDR_MODE
- rd_data  in  8  from iic_control
- rw_done  in  1  from iic_control, one-cycle pulse
- ack  in  1  from iic_control; 0 = ACK

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - every output is 0, except device_id and addr_mode, which are constants;
  - state IDLE, last-served pointer = 1, so port 0 wins first.
- States: IDLE, ISSUE, WAIT, GAP, DONE.
- IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port not served last.
  - On a grant, latch rd/addr/wdata/dly of the granted port, clear retry_cnt, then go to ISSUE.
- ISSUE:
  - Pulse rdreg_req (rd=1) or wrreg_req (rd=0) for exactly one cycle.
  - addr, wr_data and dly_cnt_max show the latched values from this cycle until leaving WAIT.
  - Clear tmo_cnt, then go to WAIT.
- WAIT:
  - tmo_cnt increments every cycle.
  - rw_done with ack=0: capture rd_data, err=0, go to DONE.
  - rw_done with ack=1 and retry_cnt < MAX_RETRY: retry_cnt+1, go to GAP.
  - rw_done with ack=1 and retry_cnt == MAX_RETRY: err=1, go to DONE.
  - tmo_cnt == TIMEOUT_CYC + latched dly, saturating at 32'hFFFF_FFFF, with no rw_done: err=1, set bus_fault, go to DONE.
  - If rw_done arrives in the same cycle as the timeout, rw_done wins.
- GAP: count RETRY_GAP_CYC cycles, then go to ISSUE. RETRY_GAP_CYC = 0 means exactly one GAP cycle.
- DONE:
  - Assert the granted port's done and err for one cycle; rdata for that port updates on the same edge.
  - Update the last-served pointer, then go to IDLE.
  - dly_cnt_max returns to 0.
- Latency: ISSUE comes one cycle after the grant cycle. done comes two cycles after the successful rw_done edge: WAIT to DONE, then done registered.
- Requester rule: req must be low in the cycle after done.
  - A req still high there is treated as a new request.
  - That new request loses to a pending request from the other port.
- Ignored inputs: rw_done outside WAIT; req changes while granted.
- Reset mid-transaction: abort immediately; no done is issued for the aborted transaction.
- bus_fault clears only on reset.
- Width rules: retry_cnt is 3 bits, gap_cnt 16 bits, tmo_cnt 32 bits. Limit addition saturates, never wraps.

Decomposition:
- Package sccb_arb_pkg holds:
  - the state encoding localparams (IDLE=0, ISSUE=1, WAIT=2, GAP=3, DONE=4, 3 bits);
  - the RD/WR opcode constants.
- One natural sub-module, sccb_rr_pick: a combinational 2-way round-robin picker taking (req[1:0], last) and returning (grant_valid, grant_idx).
- All counters and the FSM stay in the top.

Test Plan:
- Single write: r0 requests addr 16'h3008, wdata 8'h82, dly 32'h40000. Require a wrreg_req pulse with addr 3008 and dly_cnt_max 40000. Model returns rw_done with ack=0 → r0_done=1, r0_err=0, exactly once.
- Contention: r0 and r1 request in the same cycle after reset → r0 served first, then r1. With both still requesting, the next two grants are r0 then r1 (alternation).
- NACK retry, MAX_RETRY=3: model NACKs twice, then ACKs. Require 3 wrreg_req pulses spaced ≥500 idle cycles, then done with err=0. With 4 NACKs → 4 pulses, then err=1.
- Timeout: model never returns rw_done, TIMEOUT_CYC=1000, dly=0. Require done and err at WAIT cycle 1000, bus_fault=1 and sticky, and the next request is still served normally.
- Read: r1 reads 16'h300A, model returns rd_data 8'h56 with ack=0. Require r1_rdata=8'h56 with r1_done, held until the next r1 grant. A stray rw_done pulse injected in IDLE produces no done.
- Reset mid-WAIT: assert i_sysrst during WAIT. Require all outputs 0 immediately and no done afterwards. The post-reset request sequence behaves as from power-up.
